// File: rtl/conv_acc_pkg.sv
// Shared definitions for the convolution-accelerator memory masters.
// Provides bus widths, the write-enable polarity for BRAM byte requests,
// the burst-master FSM state type and a helper that builds a W_req vector.
package conv_acc_pkg;

    localparam int DATA_BUS_WIDTH = 32;
    localparam int ADDR_BUS_WIDTH = 32;
    localparam int BE_W           = DATA_BUS_WIDTH / 8;

    // Polarity of one W_req bit that requests a byte write.
    localparam logic WRITE_ENB = 1'b1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR       = 2'd1,
        RD       = 2'd2,
        RD_DRAIN = 2'd3
    } bram_state_e;

    // All byte lanes write on a write access, none on anything else.
    function automatic logic [BE_W-1:0] w_req_vec(input logic is_write);
        logic [BE_W-1:0] vec;
        if (is_write) begin
            vec = {BE_W{WRITE_ENB}};
        end else begin
            vec = {BE_W{~WRITE_ENB}};
        end
        return vec;
    endfunction

endpackage

// File: rtl/bram_burst_master_rd_fifo.sv
// bram_rd_fifo: two-entry FIFO buffering read words (data plus last flag)
// between the 1-cycle-latency BRAM and the ready/valid read port.
// Ports:
//   clk, rst     - clock, synchronous active-high reset (empties the FIFO)
//   push_i       - write push_data_i at the tail
//   push_data_i  - entry to store
//   pop_i        - drop the head entry (only while count_o != 0)
//   pop_data_o   - head entry
//   count_o      - occupancy 0..2
module bram_rd_fifo #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q ^ push_i;
        rd_ptr_d = rd_ptr_q ^ pop_i;
        count_d  = count_q + {1'b0, push_i} - {1'b0, pop_i};
    end

    // Storage, pointers and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= {WIDTH{1'b0}};
            mem_q[1] <= {WIDTH{1'b0}};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

endmodule

// File: rtl/bram_burst_master.sv
// bram_burst_master: turns one command (dir, byte address, length) into a
// burst of word accesses on a single-port BRAM.
// Ports:
//   cmd_*      - command handshake; cmd_len is words minus one
//   wr_*       - write-word stream consumed during a write burst
//   rd_*       - read-word stream produced during a read burst, rd_last on final word
//   done       - one-cycle completion pulse
//   intf_*     - BRAM master side: en, addr, W_req, W_data out; R_data in (1-cycle latency)
module bram_burst_master
    import conv_acc_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_BUS_WIDTH-1:0] cmd_addr,
    input  logic [LEN_W-1:0]          cmd_len,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [DATA_BUS_WIDTH-1:0] wr_data,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [DATA_BUS_WIDTH-1:0] rd_data,
    output logic                      rd_last,
    output logic                      done,
    output logic                      intf_en,
    output logic [ADDR_BUS_WIDTH-1:0] intf_addr,
    output logic [BE_W-1:0]           intf_W_req,
    output logic [DATA_BUS_WIDTH-1:0] intf_W_data,
    input  logic [DATA_BUS_WIDTH-1:0] intf_R_data
);

    localparam logic [ADDR_BUS_WIDTH-1:0] ADDR_MASK = {{(ADDR_BUS_WIDTH-2){1'b1}}, 2'b00};
    localparam logic [ADDR_BUS_WIDTH-1:0] ADDR_STEP = {{(ADDR_BUS_WIDTH-3){1'b0}}, 3'd4};
    localparam logic [LEN_W-1:0]          CNT_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};

    bram_state_e               state_q, state_d;
    logic [ADDR_BUS_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]          len_q, len_d;
    logic [LEN_W-1:0]          cnt_q, cnt_d;
    logic                      done_q, done_d;
    logic                      pend_q, pend_d;           // read issued last cycle
    logic                      pend_last_q, pend_last_d; // that read was the final one

    logic                      issue_s, wr_s, last_s, room_s, pop_s, drain_done_s;
    logic                      cmd_ready_s, wr_ready_s;
    logic [1:0]                fifo_count_s;
    logic [DATA_BUS_WIDTH:0]   fifo_head_s;

    assign last_s = (cnt_q == len_q);
    assign pop_s  = rd_valid & rd_ready;
    // A pop this cycle frees a slot, so credit it; this is what sustains
    // one word per cycle when rd_ready stays high.
    assign room_s = (({1'b0, fifo_count_s} + {2'b00, pend_q} - {2'b00, pop_s}) < 3'd2);

    // FSM next state, burst counters and issue decode.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        done_d       = 1'b0;
        issue_s      = 1'b0;
        wr_s         = 1'b0;
        drain_done_s = 1'b0;
        cmd_ready_s  = 1'b0;
        wr_ready_s   = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready_s = 1'b1;
                if (cmd_valid) begin
                    addr_d  = cmd_addr & ADDR_MASK;
                    len_d   = cmd_len;
                    cnt_d   = {LEN_W{1'b0}};
                    state_d = cmd_write ? WR : RD;
                end else begin
                    state_d = IDLE;
                end
            end
            WR: begin
                wr_ready_s = 1'b1;
                if (wr_valid) begin
                    issue_s = 1'b1;
                    wr_s    = 1'b1;
                    addr_d  = addr_q + ADDR_STEP;
                    cnt_d   = cnt_q + CNT_ONE;
                    if (last_s) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = WR;
                    end
                end else begin
                    state_d = WR;
                end
            end
            RD: begin
                if (room_s) begin
                    issue_s = 1'b1;
                    addr_d  = addr_q + ADDR_STEP;
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = last_s ? RD_DRAIN : RD;
                end else begin
                    state_d = RD;
                end
            end
            RD_DRAIN: begin
                if (pop_s && fifo_head_s[DATA_BUS_WIDTH]) begin
                    state_d      = IDLE;
                    drain_done_s = 1'b1;
                end else begin
                    state_d = RD_DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        pend_d      = issue_s & ~wr_s;
        pend_last_d = issue_s & ~wr_s & last_s;
    end

    // State and burst registers; reset drops any in-flight read.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= {ADDR_BUS_WIDTH{1'b0}};
            len_q       <= {LEN_W{1'b0}};
            cnt_q       <= {LEN_W{1'b0}};
            done_q      <= 1'b0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            pend_q      <= pend_d;
            pend_last_q <= pend_last_d;
        end
    end

    bram_rd_fifo #(
        .WIDTH(DATA_BUS_WIDTH + 1)
    ) u_rd_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (pend_q),
        .push_data_i({pend_last_q, intf_R_data}),
        .pop_i      (pop_s),
        .pop_data_o (fifo_head_s),
        .count_o    (fifo_count_s)
    );

    assign cmd_ready   = cmd_ready_s;
    assign wr_ready    = wr_ready_s;
    assign rd_valid    = (fifo_count_s != 2'd0);
    assign rd_data     = fifo_head_s[DATA_BUS_WIDTH-1:0];
    assign rd_last     = rd_valid & fifo_head_s[DATA_BUS_WIDTH];
    // Write completion is registered (next cycle); read completion coincides with the last pop.
    assign done        = done_q | drain_done_s;
    assign intf_en     = issue_s;
    assign intf_addr   = addr_q;
    assign intf_W_req  = w_req_vec(wr_s);
    assign intf_W_data = wr_s ? wr_data : {DATA_BUS_WIDTH{1'b0}};

endmodule

// File: tb/tb_bram_burst_master.sv
module tb_bram_burst_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid, rd_ready, rd_last, done;
    logic [31:0] rd_data;
    logic        bram_en;
    logic [31:0] bram_addr, bram_w_data;
    logic [3:0]  bram_w_req;
    logic [31:0] bram_r_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [1024];

    bram_burst_master #(.LEN_W(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .rd_last(rd_last), .done(done),
        .intf_en(bram_en), .intf_addr(bram_addr), .intf_W_req(bram_w_req),
        .intf_W_data(bram_w_data), .intf_R_data(bram_r_data)
    );

    always #5 clk = ~clk;

    // BRAM model: 1-cycle read latency, full-word writes.
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_w_req == 4'hF) mem[bram_addr[11:2]] <= bram_w_data;
            bram_r_data <= mem[bram_addr[11:2]];
        end
    end

    task automatic run_write(input logic [31:0] a, input int len, input bit toggle,
                             input logic [31:0] base, input string tag);
        logic [31:0] ea;
        int k, cyc;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_len = len[7:0];
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL %s cmd_ready got %b exp 1", tag, cmd_ready); end
        @(negedge clk);
        cmd_valid = 1'b0;
        ea = a & 32'hFFFF_FFFC; k = 0; cyc = 0;
        while (k <= len && cyc < 100) begin
            wr_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
            wr_data  = base + k;
            #1;
            checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL %s wr_ready got %b exp 1", tag, wr_ready); end
            checks++; if (bram_en !== wr_valid) begin errors++; $display("FAIL %s en got %b exp %b cyc %0d", tag, bram_en, wr_valid, cyc); end
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s early done got %b exp 0", tag, done); end
            if (wr_valid) begin
                checks++; if (bram_addr !== ea) begin errors++; $display("FAIL %s addr got %h exp %h", tag, bram_addr, ea); end
                checks++; if (bram_w_req !== 4'hF) begin errors++; $display("FAIL %s w_req got %h exp f", tag, bram_w_req); end
                checks++; if (bram_w_data !== base + k) begin errors++; $display("FAIL %s w_data got %h exp %h", tag, bram_w_data, base + k); end
                ea = ea + 32'd4;
                k++;
            end
            cyc++;
            @(negedge clk);
        end
        // wr_valid held high in IDLE must be ignored
        wr_valid = 1'b1;
        #1;
        checks++; if (k != len + 1) begin errors++; $display("FAIL %s writes got %0d exp %0d", tag, k, len + 1); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL %s done got %b exp 1", tag, done); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL %s idle cmd_ready got %b exp 1", tag, cmd_ready); end
        checks++; if (wr_ready !== 1'b0 || bram_en !== 1'b0) begin errors++; $display("FAIL %s idle wr_ready/en got %b/%b exp 0/0", tag, wr_ready, bram_en); end
        @(negedge clk);
        wr_valid = 1'b0;
        #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s done width got %b exp 0", tag, done); end
    endtask

    task automatic run_read(input logic [31:0] a, input int len, input int duty,
                            input logic [31:0] ev [8], input string tag);
        logic [31:0] ea;
        int got, cyc, occ_m, issued, first_pop, last_pop;
        logic infl_m, pop;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_len = len[7:0];
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL %s cmd_ready got %b exp 1", tag, cmd_ready); end
        @(negedge clk);
        cmd_valid = 1'b0;
        ea = a & 32'hFFFF_FFFC; got = 0; cyc = 0; occ_m = 0; infl_m = 1'b0; issued = 0;
        first_pop = -1; last_pop = -1;
        while (got < len + 1 && cyc < 400) begin
            rd_ready = (duty >= 100) ? 1'b1 : ($urandom_range(99) < duty);
            #1;
            pop = rd_valid & rd_ready;
            checks++; if (rd_valid !== (occ_m != 0)) begin errors++; $display("FAIL %s rd_valid got %b exp %b", tag, rd_valid, occ_m != 0); end
            if (bram_en) begin
                checks++; if (bram_addr !== ea) begin errors++; $display("FAIL %s addr got %h exp %h", tag, bram_addr, ea); end
                checks++; if (bram_w_req !== 4'h0) begin errors++; $display("FAIL %s w_req got %h exp 0", tag, bram_w_req); end
                checks++; if (occ_m + int'(infl_m) - int'(pop) >= 2) begin errors++; $display("FAIL %s en with fifo+inflight %0d exp <2", tag, occ_m + int'(infl_m) - int'(pop)); end
                ea = ea + 32'd4;
                issued++;
            end
            if (pop) begin
                checks++; if (rd_data !== ev[got]) begin errors++; $display("FAIL %s rd_data[%0d] got %h exp %h", tag, got, rd_data, ev[got]); end
                checks++; if (rd_last !== (got == len)) begin errors++; $display("FAIL %s rd_last[%0d] got %b exp %b", tag, got, rd_last, got == len); end
                checks++; if (done !== (got == len)) begin errors++; $display("FAIL %s done[%0d] got %b exp %b", tag, got, done, got == len); end
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
                got++;
            end else begin
                checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s done without pop got %b exp 0", tag, done); end
            end
            occ_m  = occ_m + int'(infl_m) - int'(pop);
            infl_m = bram_en;
            cyc++;
            @(negedge clk);
        end
        rd_ready = 1'b0;
        #1;
        checks++; if (got != len + 1) begin errors++; $display("FAIL %s words got %0d exp %0d (timeout)", tag, got, len + 1); end
        checks++; if (issued != len + 1) begin errors++; $display("FAIL %s issues got %0d exp %0d", tag, issued, len + 1); end
        checks++; if (cmd_ready !== 1'b1 || done !== 1'b0 || rd_valid !== 1'b0) begin
            errors++; $display("FAIL %s end cmd_ready/done/rd_valid got %b/%b/%b exp 1/0/0", tag, cmd_ready, done, rd_valid);
        end
        if (duty >= 100) begin
            checks++; if (last_pop - first_pop != len) begin errors++; $display("FAIL %s throughput span got %0d exp %0d", tag, last_pop - first_pop, len); end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset cmd_ready got %b exp 1", cmd_ready); end
        checks++; if (bram_en !== 1'b0 || bram_addr !== 32'h0) begin errors++; $display("FAIL reset en/addr got %b/%h exp 0/0", bram_en, bram_addr); end
        checks++; if (bram_w_req !== 4'h0 || bram_w_data !== 32'h0) begin errors++; $display("FAIL reset w_req/w_data got %h/%h exp 0/0", bram_w_req, bram_w_data); end
        checks++; if (wr_ready !== 1'b0 || rd_valid !== 1'b0 || rd_last !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL reset wr_ready/rd_valid/rd_last/done got %b%b%b%b exp 0000", wr_ready, rd_valid, rd_last, done);
        end
    endtask

    task automatic test_write_burst();
        run_write(32'h100, 3, 1'b0, 32'hA0, "wr_burst");
    endtask

    task automatic test_read_burst();
        logic [31:0] ev [8];
        for (int i = 0; i < 8; i++) ev[i] = 32'hA0 + i;
        run_read(32'h100, 3, 100, ev, "rd_burst");
    endtask

    task automatic test_read_backpressure();
        logic [31:0] ev [8];
        for (int i = 0; i < 8; i++) ev[i] = 32'hA0 + i;
        run_read(32'h100, 3, 30, ev, "rd_bp30");
    endtask

    task automatic test_write_stall();
        run_write(32'h103, 3, 1'b1, 32'hB0, "wr_stall");
        for (int i = 0; i < 4; i++) begin
            checks++; if (mem[10'h40 + i] !== 32'hB0 + i) begin errors++; $display("FAIL wr_stall mem[%0h] got %h exp %h", 10'h40 + i, mem[10'h40 + i], 32'hB0 + i); end
        end
    endtask

    task automatic test_len0();
        logic [31:0] ev [8];
        for (int i = 0; i < 8; i++) ev[i] = 32'h0;
        ev[0] = 32'h55;
        run_write(32'h300, 0, 1'b0, 32'h55, "wr_len0");
        run_read(32'h300, 0, 100, ev, "rd_len0");
    endtask

    task automatic test_addr_wrap();
        logic [31:0] ev [8];
        for (int i = 0; i < 8; i++) ev[i] = 32'h0;
        ev[0] = 32'hC000_03FF;
        ev[1] = 32'hC000_0000;
        run_read(32'hFFFF_FFFC, 1, 100, ev, "rd_wrap");
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] ev [8];
        int pops, cyc;
        for (int i = 0; i < 8; i++) ev[i] = 32'hB0 + i;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h100; cmd_len = 8'd7; rd_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        pops = 0; cyc = 0;
        while (pops < 1 && cyc < 20) begin
            #1;
            if (rd_valid && rd_ready) pops++;
            cyc++;
            @(negedge clk);
        end
        checks++; if (pops != 1) begin errors++; $display("FAIL rst_mid first word got %0d exp 1", pops); end
        rst = 1'b1;
        #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_mid done at word2 got %b exp 0", done); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (cmd_ready !== 1'b1 || rd_valid !== 1'b0 || bram_en !== 1'b0) begin
            errors++; $display("FAIL rst_mid after cmd_ready/rd_valid/en got %b/%b/%b exp 1/0/0", cmd_ready, rd_valid, bram_en);
        end
        repeat (3) begin
            @(negedge clk);
            #1;
            checks++; if (rd_valid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_mid quiet rd_valid/done got %b/%b exp 0/0", rd_valid, done); end
        end
        rd_ready = 1'b0;
        run_read(32'h100, 3, 100, ev, "rd_after_rst");
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hC000_0000 + i;
        bram_r_data = 32'h0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_len = 8'd0;
        wr_valid = 1'b0; wr_data = 32'h0; rd_ready = 1'b0;
        test_reset();
        test_write_burst();
        test_read_burst();
        test_read_backpressure();
        test_write_stall();
        test_len0();
        test_addr_wrap();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
